// File: rtl/esm_issue_select.sv
// Issue-select stage: tracks buffer slots, their dependency rows,
// and offers the lowest-index ready slot over a valid/ready handshake.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alloc_valid/index/dep     write a dependency row into a slot
//   issue_valid/index/ready   offered slot and downstream acceptance
//   done_valid/index          completion notice, frees a slot
//   ready_mask                registered per-slot ready vector
//   occupancy                 number of valid slots
//   err                       sticky protocol-error flag
module esm_issue_select #(
    parameter int bs = 16,
    localparam int IW = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    input  logic [IW-1:0] alloc_index,
    input  logic [bs-1:0] alloc_dep,
    output logic          issue_valid,
    output logic [IW-1:0] issue_index,
    input  logic          issue_ready,
    input  logic          done_valid,
    input  logic [IW-1:0] done_index,
    output logic [bs-1:0] ready_mask,
    output logic [IW:0]   occupancy,
    output logic          err
);

    logic [bs-1:0]          valid;
    logic [bs-1:0]          issued;
    logic [bs-1:0][bs-1:0]  dep;

    logic [bs-1:0]          valid_n;
    logic [bs-1:0]          issued_n;
    logic [bs-1:0][bs-1:0]  dep_n;
    logic [bs-1:0]          ready_n;
    logic [bs-1:0]          row;
    logic [bs-1:0]          cand;
    logic [IW:0]            occ_n;
    logic [IW-1:0]          pick;
    logic                   hs;
    logic                   done_ok;
    logic                   err_n;
    logic                   iv_n;
    logic [IW-1:0]          ii_n;

    always_comb begin
        hs       = issue_valid & issue_ready;
        done_ok  = done_valid & valid[done_index] & issued[done_index];
        valid_n  = valid;
        issued_n = issued;
        dep_n    = dep;
        row      = '0;

        if (hs)
            issued_n[issue_index] = 1'b1;

        // Free the slot and wake every waiter on it.
        if (done_ok) begin
            valid_n[done_index]  = 1'b0;
            issued_n[done_index] = 1'b0;
            for (int i = 0; i < bs; i++)
                dep_n[i][done_index] = 1'b0;
        end

        // Alloc is applied after done so a same-slot pair
        // replaces the old occupant with the new one.
        if (alloc_valid) begin
            row = alloc_dep & valid;
            row[alloc_index] = 1'b0;
            if (done_ok)
                row[done_index] = 1'b0;
            dep_n[alloc_index]    = row;
            valid_n[alloc_index]  = 1'b1;
            issued_n[alloc_index] = 1'b0;
        end

        err_n = err
              | (alloc_valid & valid[alloc_index]
                 & ~(done_ok & (done_index == alloc_index)))
              | (done_valid & ~done_ok);

        occ_n = '0;
        for (int i = 0; i < bs; i++) begin
            ready_n[i] = valid_n[i] & ~issued_n[i] & ~(|dep_n[i]);
            occ_n = occ_n + {{IW{1'b0}}, valid_n[i]};
        end

        // Candidate set excludes the slot accepted at this edge.
        cand = ready_mask;
        if (hs)
            cand[issue_index] = 1'b0;

        pick = '0;
        for (int i = bs - 1; i >= 0; i--)
            if (cand[i])
                pick = IW'(i);

        iv_n = issue_valid;
        ii_n = issue_index;
        if (!issue_valid || hs) begin
            iv_n = |cand;
            ii_n = pick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            issued      <= '0;
            dep         <= '0;
            ready_mask  <= '0;
            occupancy   <= '0;
            err         <= 1'b0;
            issue_valid <= 1'b0;
            issue_index <= '0;
        end else begin
            valid       <= valid_n;
            issued      <= issued_n;
            dep         <= dep_n;
            ready_mask  <= ready_n;
            occupancy   <= occ_n;
            err         <= err_n;
            issue_valid <= iv_n;
            issue_index <= ii_n;
        end
    end

endmodule

// File: doc/esm_issue_select.md
Name: esm_issue_select

Overview:
- Consumer side of the instruction dependency analysis (IDA) stage.
- Receives one dependency row per buffer slot from IDA and tracks slot occupancy.
- Picks the lowest-index slot whose dependencies are all resolved and offers it downstream over a valid/ready handshake.
- On a completion notice, frees the slot and clears its column in every stored row, so waiting instructions wake up.

Parameters:
- bs, 16, instruction buffer depth (number of slots); power of two, at least 2.
- IW, $clog2(bs), slot index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  a new dependency row is presented this cycle.
- alloc_index  in  IW  buffer slot being written.
- alloc_dep  in  bs  dependency row; bit j=1 means the slot depends on slot j.
- issue_valid  out  1  issue_index holds a ready, not-yet-issued slot.
- issue_index  out  IW  slot offered for issue.
- issue_ready  in  1  downstream accepts the offered slot.
- done_valid  in  1  a completion notice is presented this cycle.
- done_index  in  IW  slot that completed.
- ready_mask  out  bs  per-slot: valid, not issued, and all dependency bits zero (registered).
- occupancy  out  IW+1  count of valid slots.
- err  out  1  sticky protocol-error flag.

Behaviour:
- State per slot: valid bit, issued bit, bs-bit dependency row. All registers update on posedge clk.
- Reset (rst=1 at an edge, including mid-operation):
  - All valid, issued and row bits are cleared.
  - issue_valid=0, issue_index=0, ready_mask=0, occupancy=0, err=0.
  - Inputs are ignored during that cycle.
- Allocation (alloc_valid=1):
  - The slot becomes valid with issued=0.
  - Stored row = alloc_dep AND the current valid vector, with its own diagonal bit forced to 0. Dependencies on empty slots count as already resolved.
  - If the slot was already valid and is not being freed by done this cycle: the row is overwritten, occupancy is unchanged, and err is set.
- Completion (done_valid=1):
  - If slot done_index is valid and issued: it becomes invalid and bit done_index is cleared in all rows, including a row being allocated in the same cycle.
  - Otherwise the notice is ignored and err is set.
- Same-cycle alloc and done to the same index: done frees the old occupant first, then alloc writes the new one. Occupancy is unchanged and no error is raised.
- occupancy = popcount of valid after each edge. It cannot exceed bs.
- ready_mask is recomputed from state each edge and reflects post-update state.
- Issue handshake:
  - issue_valid and issue_index are registers.
  - While issue_valid=1 and issue_ready=0, both hold stable, even if a lower-index slot becomes ready.
  - Handshake = issue_valid AND issue_ready. At that edge the offered slot's issued bit is set.
  - When issue_valid=0 or a handshake occurs: at the edge, load the lowest set index of (ready_mask excluding the slot being accepted). issue_valid=1 if such an index exists, else issue_valid=0 and issue_index=0.
  - If the offered slot is freed by done before it is accepted, that done is a protocol error (slot not issued): it is ignored and err is set.
- Latency:
  - Dependency-free alloc sampled at edge N → ready_mask bit set after N → issue_valid=1 after edge N+1.
  - done at edge N clearing the last dependency of slot k → slot k can be offered after edge N+1.
- Back-to-back: with issue_ready held at 1 and several slots ready, one slot is issued per cycle in ascending index order.
- Wrap-around: slot indices are reused freely. Order is by index only, not by age.

Test Plan:
- Reset, then alloc slot 3 with dep=0 at edge 1 → issue_valid=1, issue_index=3 after edge 2; handshake at edge 3 → issue_valid=0, ready_mask=0, occupancy=1.
- Alloc slot 0 with dep=0x0000 and slot 1 with dep=0x0001; issue and complete slot 0 (done_index=0) → slot 1 row clears; issue_valid=1, issue_index=1 two edges after the done.
- Alloc slots 2, 5, 7, all dep=0, with issue_ready=1 → issue_index sequence 2, 5, 7 on consecutive cycles; then issue_valid=0; occupancy=3.
- Hold issue_ready=0 while slot 6 is offered, then alloc ready slot 1 → issue_index stays 6 until the handshake, then 1 is offered next.
- Alloc slot 4 with dep=0x8010 while slot 15 is empty → stored row has the self bit and bit 15 cleared; slot 4 is ready immediately. Then done_index=9 on an empty slot → ignored, err=1.
- Same-cycle alloc and done to slot 8 (slot 8 issued) → occupancy unchanged, new row stored, err=0. Assert rst mid-stream → all outputs 0 the following cycle.
